// File: rtl/regfile_context_engine.sv
// -----------------------------------------------------------------------------
// regfile_context_engine
//
// Save/restore sequencer for the register file. On a start command it walks
// every register index once:
//   save    (mode=0): reads register i and writes it to memory word base+i
//   restore (mode=1): reads memory word base+i and writes it to register i
// Both the register file and the data memory return read data one cycle after
// the address is presented. The engine therefore issues index i in one cycle
// and completes it in the next, which gives one word per cycle.
//
// Ports
//   clk         clock, all state updates on the rising edge
//   rst         synchronous active-high reset; aborts any operation in flight
//   start       command strobe, only honoured while idle
//   mode        0 = save (regfile -> mem), 1 = restore (mem -> regfile)
//   base_addr   first memory word address of the context window
//   busy        high while indices are being issued or drained
//   done        one-cycle pulse when the operation has finished
//   rf_addr_rd  regfile read address (save mode)
//   rf_q        regfile read data, valid one cycle after rf_addr_rd
//   rf_addr_wr  regfile write address (restore mode)
//   rf_data     regfile write data (restore mode)
//   rf_we       regfile write enable (restore mode)
//   mem_addr    memory address: write address in save mode, read address in
//               restore mode
//   mem_wdata   memory write data (save mode)
//   mem_we      memory write enable (save mode)
//   mem_rdata   memory read data, valid one cycle after mem_addr
// -----------------------------------------------------------------------------
module regfile_context_engine #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 4,
  parameter int MEM_ADDR_WIDTH = 16,
  parameter int PROTECT_LAST   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      mode,
  input  logic [MEM_ADDR_WIDTH-1:0] base_addr,
  output logic                      busy,
  output logic                      done,
  output logic [ADDR_WIDTH-1:0]     rf_addr_rd,
  input  logic [DATA_WIDTH-1:0]     rf_q,
  output logic [ADDR_WIDTH-1:0]     rf_addr_wr,
  output logic [DATA_WIDTH-1:0]     rf_data,
  output logic                      rf_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic                      mem_we,
  input  logic [DATA_WIDTH-1:0]     mem_rdata
);

  localparam logic [ADDR_WIDTH-1:0]     LAST_IDX  = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0]     IDX_ZERO  = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0]     IDX_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [MEM_ADDR_WIDTH-1:0] MADDR_ZERO = {MEM_ADDR_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0]     DATA_ZERO = {DATA_WIDTH{1'b0}};
  localparam logic                      MODE_SAVE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Sequencer state
  state_e                      state_q, state_d;
  logic [ADDR_WIDTH-1:0]       idx_q, idx_d;       // index being issued
  logic                        pend_q, pend_d;     // an index awaits completion
  logic [ADDR_WIDTH-1:0]       pidx_q, pidx_d;     // index awaiting completion
  logic                        mode_q, mode_d;
  logic [MEM_ADDR_WIDTH-1:0]   base_q, base_d;

  // Registered control/address outputs
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic [ADDR_WIDTH-1:0]       rf_addr_rd_q, rf_addr_rd_d;
  logic [ADDR_WIDTH-1:0]       rf_addr_wr_q, rf_addr_wr_d;
  logic                        rf_we_q, rf_we_d;
  logic [MEM_ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic                        mem_we_q, mem_we_d;

  logic                        complete_s;

  // Zero-extend a register index into the memory address space.
  function automatic logic [MEM_ADDR_WIDTH-1:0] widen_idx(input logic [ADDR_WIDTH-1:0] idx);
    widen_idx = MEM_ADDR_WIDTH'(idx);
  endfunction

  // Next-state logic of the save/restore sequencer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    pidx_d  = pidx_q;
    mode_d  = mode_q;
    base_d  = base_q;
    case (state_q)
      ST_IDLE: begin
        pend_d = 1'b0;
        if (start) begin
          mode_d  = mode;
          base_d  = base_addr;
          idx_d   = IDX_ZERO;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // The index issued now completes in the following cycle.
        pend_d = 1'b1;
        pidx_d = idx_q;
        if (idx_q == LAST_IDX) begin
          state_d = ST_DRAIN;
        end else begin
          idx_d   = idx_q + IDX_ONE;
          state_d = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        pend_d  = 1'b0;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        pend_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        pend_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state so that
  // the outputs can be registered without adding a cycle of latency.
  always_comb begin
    busy_d       = 1'b0;
    done_d       = 1'b0;
    rf_addr_rd_d = IDX_ZERO;
    rf_addr_wr_d = IDX_ZERO;
    rf_we_d      = 1'b0;
    mem_addr_d   = MADDR_ZERO;
    mem_we_d     = 1'b0;
    complete_s   = pend_d && ((state_d == ST_ISSUE) || (state_d == ST_DRAIN));

    busy_d = (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);

    if (mode_d == MODE_SAVE) begin
      if (state_d == ST_ISSUE) begin
        rf_addr_rd_d = idx_d;
      end else begin
        rf_addr_rd_d = IDX_ZERO;
      end
      // In save mode mem_addr only ever carries the write address.
      if (complete_s) begin
        mem_we_d   = 1'b1;
        mem_addr_d = base_d + widen_idx(pidx_d);
      end else begin
        mem_we_d   = 1'b0;
        mem_addr_d = MADDR_ZERO;
      end
    end else begin
      if (state_d == ST_ISSUE) begin
        mem_addr_d = base_d + widen_idx(idx_d);
      end else begin
        mem_addr_d = MADDR_ZERO;
      end
      if (complete_s) begin
        rf_addr_wr_d = pidx_d;
        // The last register holds the window pointer and may be protected.
        rf_we_d      = !((PROTECT_LAST != 0) && (pidx_d == LAST_IDX));
      end else begin
        rf_addr_wr_d = IDX_ZERO;
        rf_we_d      = 1'b0;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= IDX_ZERO;
      pend_q       <= 1'b0;
      pidx_q       <= IDX_ZERO;
      mode_q       <= 1'b0;
      base_q       <= MADDR_ZERO;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rf_addr_rd_q <= IDX_ZERO;
      rf_addr_wr_q <= IDX_ZERO;
      rf_we_q      <= 1'b0;
      mem_addr_q   <= MADDR_ZERO;
      mem_we_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      pidx_q       <= pidx_d;
      mode_q       <= mode_d;
      base_q       <= base_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rf_addr_rd_q <= rf_addr_rd_d;
      rf_addr_wr_q <= rf_addr_wr_d;
      rf_we_q      <= rf_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
    end
  end

  // Write data arrives from the source one cycle after its address, i.e. in
  // the completion cycle itself, so it is forwarded combinationally and gated
  // to zero whenever no write is taking place.
  always_comb begin
    if (mem_we_q) begin
      mem_wdata = rf_q;
    end else begin
      mem_wdata = DATA_ZERO;
    end
    if (rf_we_q) begin
      rf_data = mem_rdata;
    end else begin
      rf_data = DATA_ZERO;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign rf_addr_rd = rf_addr_rd_q;
  assign rf_addr_wr = rf_addr_wr_q;
  assign rf_we      = rf_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;

endmodule

// File: tb/tb_regfile_context_engine.sv
// Bench for regfile_context_engine. The register file and the data memory are
// modelled here as plain arrays with one-cycle read latency. Expected results
// are computed from the save/restore rules (whole-window copies, modular
// addresses, protected last register) and compared against the arrays.
module tb_regfile_context_engine;
  localparam int NR  = 16;
  localparam int MSZ = 65536;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] base_addr = 16'h0000;
  logic        busy, done, rf_we, mem_we;
  logic [3:0]  rf_addr_rd, rf_addr_wr;
  logic [31:0] rf_q = 32'h0, rf_data, mem_wdata, mem_rdata = 32'h0;
  logic [15:0] mem_addr;

  logic [31:0] rf [NR];
  logic [31:0] exp_rf [NR];
  logic [31:0] mem [MSZ];
  logic [31:0] exp_mem [MSZ];
  logic [31:0] rdq_nxt = 32'h0, mrd_nxt = 32'h0;
  logic [91:0] outv;

  int cyc = 0, total = 0, bad = 0, t0 = 0;
  int wr_cyc[$], wr_addr[$], rfw_cyc[$], done_q[$], busy_q[$];

  regfile_context_engine #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .MEM_ADDR_WIDTH(16), .PROTECT_LAST(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .base_addr(base_addr),
    .busy(busy), .done(done), .rf_addr_rd(rf_addr_rd), .rf_q(rf_q),
    .rf_addr_wr(rf_addr_wr), .rf_data(rf_data), .rf_we(rf_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // read data of the memories appears one cycle after the address
  always @(posedge clk) begin
    rf_q      <= rdq_nxt;
    mem_rdata <= mrd_nxt;
  end

  // advance to the next falling edge, observe the DUT and update the memories
  task automatic step();
    @(negedge clk);
    cyc++;
    if (mem_we === 1'b1) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(int'(mem_addr));
      mem[mem_addr] = mem_wdata;
    end
    if (rf_we === 1'b1) begin
      rfw_cyc.push_back(cyc);
      rf[rf_addr_wr] = rf_data;
    end
    if (done === 1'b1) done_q.push_back(cyc);
    if (busy === 1'b1) busy_q.push_back(cyc);
    rdq_nxt = rf[rf_addr_rd];
    mrd_nxt = mem[mem_addr];
  endtask

  task automatic launch(input logic m, input logic [15:0] b);
    mode = m;
    base_addr = b;
    start = 1'b1;
    t0 = cyc;
    wr_cyc.delete(); wr_addr.delete(); rfw_cyc.delete(); done_q.delete(); busy_q.delete();
  endtask

  task automatic wait_done(output int dcyc);
    dcyc = -1;
    for (int k = 0; k < 40 && dcyc < 0; k++) begin
      step();
      if (done === 1'b1) dcyc = cyc - t0;
    end
    if (dcyc < 0) begin
      total++; bad++;
      $display("FAIL done_timeout: no done within 40 cycles of start");
    end
  endtask

  task automatic run_op(input logic m, input logic [15:0] b, output int dcyc);
    launch(m, b);
    step();
    start = 1'b0;
    wait_done(dcyc);
  endtask

  function automatic int mem_diff();
    for (int a = 0; a < MSZ; a++) if (mem[a] !== exp_mem[a]) return a;
    return -1;
  endfunction

  function automatic int rf_diff();
    for (int r = 0; r < NR; r++) if (rf[r] !== exp_rf[r]) return r;
    return -1;
  endfunction

  // expected memory after saving the current register file at base b
  task automatic expect_save(input int b, input int count);
    exp_mem = mem;
    for (int i = 0; i < count; i++) exp_mem[(b + i) % MSZ] = rf[i];
  endtask

  // expected register file after restoring from base b (last reg protected)
  task automatic expect_restore(input int b);
    exp_rf = rf;
    for (int i = 0; i < NR - 1; i++) exp_rf[i] = mem[(b + i) % MSZ];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    outv = {busy, done, rf_we, mem_we, rf_addr_rd, rf_addr_wr, rf_data, mem_addr, mem_wdata};
    total++;
    if (outv !== 92'd0) begin bad++; $display("FAIL reset_outputs: got %h want 0", outv); end
    rst = 1'b0;
    repeat (2) step();
    outv = {busy, done, rf_we, mem_we, rf_addr_rd, rf_addr_wr, rf_data, mem_addr, mem_wdata};
    total++;
    if (outv !== 92'd0) begin bad++; $display("FAIL idle_outputs: got %h want 0", outv); end
  endtask

  task automatic test_save();
    int d, a;
    for (int i = 0; i < NR; i++) rf[i] = 32'h100 + i;
    expect_save(16'h2000, NR);
    run_op(1'b0, 16'h2000, d);
    a = mem_diff();
    total++;
    if (a !== -1) begin bad++; $display("FAIL save_image: mem[%h]=%h want %h", a, mem[a], exp_mem[a]); end
    total++;
    if (d !== 18) begin bad++; $display("FAIL save_done_cycle: got %0d want 18", d); end
    total++;
    if (wr_cyc.size() !== 16 || wr_cyc[0] - t0 !== 2 || wr_cyc[wr_cyc.size()-1] - t0 !== 17) begin
      bad++; $display("FAIL save_write_window: count=%0d want 16 in cycles 2..17", wr_cyc.size());
    end
    total++;
    if (busy_q.size() !== 17 || busy_q[0] - t0 !== 1 || busy_q[busy_q.size()-1] - t0 !== 17) begin
      bad++; $display("FAIL save_busy: count=%0d want 17 in cycles 1..17", busy_q.size());
    end
    total++;
    if (rfw_cyc.size() !== 0) begin bad++; $display("FAIL save_rf_we: got %0d pulses want 0", rfw_cyc.size()); end
  endtask

  task automatic test_restore_protect();
    int d, r;
    for (int i = 0; i < NR; i++) mem[16'h3000 + i] = 32'hA0 + i;
    for (int i = 0; i < NR - 1; i++) rf[i] = $urandom();
    rf[NR-1] = 32'h73E8;
    exp_rf = rf;
    for (int i = 0; i < NR - 1; i++) exp_rf[i] = 32'hA0 + i;
    exp_mem = mem;
    run_op(1'b1, 16'h3000, d);
    r = rf_diff();
    total++;
    if (r !== -1) begin bad++; $display("FAIL restore_image: r%0d=%h want %h", r, rf[r], exp_rf[r]); end
    total++;
    if (rfw_cyc.size() !== 15 || rfw_cyc[0] - t0 !== 2 || rfw_cyc[rfw_cyc.size()-1] - t0 !== 16) begin
      bad++; $display("FAIL restore_rf_we: count=%0d want 15 in cycles 2..16", rfw_cyc.size());
    end
    total++;
    if (wr_cyc.size() !== 0 || mem_diff() !== -1) begin
      bad++; $display("FAIL restore_mem_untouched: %0d writes want 0", wr_cyc.size());
    end
    total++;
    if (d !== 18) begin bad++; $display("FAIL restore_done_cycle: got %0d want 18", d); end
  endtask

  task automatic test_wrap();
    int d, a, badk;
    for (int i = 0; i < NR; i++) rf[i] = $urandom();
    expect_save(16'hFFFA, NR);
    run_op(1'b0, 16'hFFFA, d);
    a = mem_diff();
    total++;
    if (a !== -1) begin bad++; $display("FAIL wrap_image: mem[%h]=%h want %h", a, mem[a], exp_mem[a]); end
    badk = -1;
    for (int k = 0; k < wr_addr.size(); k++)
      if (badk < 0 && wr_addr[k] !== (16'hFFFA + k) % MSZ) badk = k;
    total++;
    if (wr_addr.size() !== 16 || badk !== -1) begin
      bad++; $display("FAIL wrap_addr_seq: count=%0d first_bad=%0d want 16 writes FFFA..0009", wr_addr.size(), badk);
    end
  endtask

  task automatic test_start_while_busy();
    int d, a;
    for (int i = 0; i < NR; i++) rf[i] = $urandom();
    expect_save(16'h4000, NR);
    launch(1'b0, 16'h4000);
    step();
    start = 1'b0;
    repeat (4) step();
    start = 1'b1; mode = 1'b1; base_addr = 16'h7777;
    step();
    start = 1'b0; mode = 1'b0;
    wait_done(d);
    repeat (3) step();
    total++;
    if (d !== 18) begin bad++; $display("FAIL busy_start_done_cycle: got %0d want 18", d); end
    total++;
    if (done_q.size() !== 1) begin bad++; $display("FAIL busy_start_done_count: got %0d want 1", done_q.size()); end
    a = mem_diff();
    total++;
    if (a !== -1 || rfw_cyc.size() !== 0) begin
      bad++; $display("FAIL busy_start_save: mem_diff=%0d rf_we=%0d want -1 and 0", a, rfw_cyc.size());
    end
  endtask

  task automatic test_reset_mid_save();
    int a;
    for (int i = 0; i < NR; i++) rf[i] = $urandom();
    expect_save(16'h5000, 7);
    launch(1'b0, 16'h5000);
    step();
    start = 1'b0;
    repeat (7) step();
    rst = 1'b1;
    step();
    outv = {busy, done, rf_we, mem_we, rf_addr_rd, rf_addr_wr, rf_data, mem_addr, mem_wdata};
    total++;
    if (outv !== 92'd0) begin bad++; $display("FAIL midreset_outputs: got %h want 0", outv); end
    rst = 1'b0;
    repeat (25) step();
    total++;
    if (done_q.size() !== 0) begin bad++; $display("FAIL midreset_done: got %0d pulses want 0", done_q.size()); end
    total++;
    if (wr_cyc.size() !== 7 || busy_q.size() !== 8) begin
      bad++; $display("FAIL midreset_counts: writes=%0d busy=%0d want 7 and 8", wr_cyc.size(), busy_q.size());
    end
    a = mem_diff();
    total++;
    if (a !== -1) begin bad++; $display("FAIL midreset_image: mem[%h]=%h want %h", a, mem[a], exp_mem[a]); end
  endtask

  task automatic test_back_to_back();
    int d1, d2, r, a;
    logic [15:0] b;
    logic [31:0] orig [NR];
    b = 16'($urandom());
    for (int i = 0; i < NR; i++) begin rf[i] = $urandom(); orig[i] = rf[i]; end
    expect_save(int'(b), NR);
    run_op(1'b0, b, d1);
    step();
    for (int i = 0; i < NR; i++) rf[i] = $urandom();
    for (int i = 0; i < NR - 1; i++) exp_rf[i] = orig[i];
    exp_rf[NR-1] = rf[NR-1];
    run_op(1'b1, b, d2);
    total++;
    if (d1 !== 18 || d2 !== 18) begin bad++; $display("FAIL b2b_done_cycles: got %0d,%0d want 18,18", d1, d2); end
    r = rf_diff();
    total++;
    if (r !== -1) begin bad++; $display("FAIL b2b_restore_image: r%0d=%h want %h", r, rf[r], exp_rf[r]); end
    a = mem_diff();
    total++;
    if (a !== -1) begin bad++; $display("FAIL b2b_mem_image: mem[%h]=%h want %h", a, mem[a], exp_mem[a]); end
  endtask

  task automatic test_random_ops();
    int d, a, r;
    logic m;
    logic [15:0] b;
    for (int n = 0; n < 6; n++) begin
      m = 1'($urandom_range(1, 0));
      b = 16'($urandom());
      for (int i = 0; i < NR; i++) begin
        rf[i] = $urandom();
        mem[(int'(b) + i) % MSZ] = $urandom();
      end
      if (m == 1'b0) begin
        expect_save(int'(b), NR);
        exp_rf = rf;
      end else begin
        expect_restore(int'(b));
        exp_mem = mem;
      end
      run_op(m, b, d);
      step();
      a = mem_diff();
      r = rf_diff();
      total++;
      if (a !== -1 || r !== -1 || d !== 18) begin
        bad++; $display("FAIL random_op%0d mode=%0d base=%h: mem_diff=%0d rf_diff=%0d done=%0d want -1,-1,18",
                        n, m, b, a, r, d);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < MSZ; a++) mem[a] = 32'h0;
    for (int i = 0; i < NR; i++) rf[i] = 32'h0;
    test_reset();
    test_save();
    step();
    test_restore_protect();
    step();
    test_wrap();
    step();
    test_start_while_busy();
    test_reset_mid_save();
    test_back_to_back();
    step();
    test_random_ops();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
